// File: rtl/mv_pkg.sv
// Shared definitions for the matrix-vector result path: node result format,
// drain state encoding and index sizing.
package mv_pkg;

    localparam int RES_DW         = 18;
    localparam int RES_INT_BITS   = 1;
    localparam int RES_FRAC_BITS  = 17;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_e;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mv_result_drain.sv
// Snapshots all node results on a capture strobe and streams them out one
// sign-extended word per beat on a valid/ready/last master port.
module mv_result_drain
    import mv_pkg::*;
#(
    parameter int N_NODES = 8,
    parameter int DW      = mv_pkg::RES_DW,
    parameter int OW      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_NODES*DW-1:0] res_flat,
    input  logic                  capture,
    output logic [OW-1:0]         m_tdata,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic                  m_tlast,
    output logic                  busy,
    output logic                  overrun,
    input  logic                  clr_overrun
);

    localparam int IW = idx_width(N_NODES);

    state_e          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [DW-1:0]   buf_q [N_NODES];
    logic            overrun_q, overrun_d;
    logic            load;
    logic            drop;
    logic            at_last;
    logic            beat;

    assign at_last = (idx_q == IW'(N_NODES - 1));
    assign beat    = (state_q == DRAIN) && m_tready;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        load      = 1'b0;
        drop      = 1'b0;
        overrun_d = overrun_q;
        case (state_q)
            IDLE: begin
                if (capture) begin
                    load    = 1'b1;
                    idx_d   = '0;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (beat && at_last) begin
                    // A capture landing on the final beat chains straight into the next snapshot.
                    if (capture) begin
                        load  = 1'b1;
                        idx_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    if (beat) begin
                        idx_d = idx_q + 1'b1;
                    end
                    drop = capture;
                end
            end
            default: state_d = IDLE;
        endcase
        if (drop) begin
            overrun_d = 1'b1;
        end else if (clr_overrun) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            overrun_q <= 1'b0;
            for (int k = 0; k < N_NODES; k++) begin
                buf_q[k] <= '0;
            end
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            overrun_q <= overrun_d;
            if (load) begin
                for (int k = 0; k < N_NODES; k++) begin
                    buf_q[k] <= res_flat[k*DW +: DW];
                end
            end
        end
    end

    assign m_tvalid = (state_q == DRAIN);
    assign busy     = (state_q == DRAIN);
    assign m_tlast  = (state_q == DRAIN) && at_last;
    assign m_tdata  = OW'($signed(buf_q[idx_q]));
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_mv_result_drain.sv
// Randomized and directed bench for mv_result_drain against a queue-of-beats
// reference model.
module tb_mv_result_drain;

    localparam int N  = 8;
    localparam int DW = 18;
    localparam int OW = 32;
    localparam int NW = N * DW;

    logic          clk = 1'b0;
    logic          rst;
    logic [NW-1:0] res_flat;
    logic          capture;
    logic [OW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tready;
    logic          m_tlast;
    logic          busy;
    logic          overrun;
    logic          clr_overrun;

    mv_result_drain #(.N_NODES(N), .DW(DW), .OW(OW)) dut (
        .clk         (clk),
        .rst         (rst),
        .res_flat    (res_flat),
        .capture     (capture),
        .m_tdata     (m_tdata),
        .m_tvalid    (m_tvalid),
        .m_tready    (m_tready),
        .m_tlast     (m_tlast),
        .busy        (busy),
        .overrun     (overrun),
        .clr_overrun (clr_overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [OW-1:0] d;
        logic          l;
    } beat_t;

    beat_t exp_q[$];
    logic  exp_ov;
    int    n_chk  = 0;
    int    n_fail = 0;

    task automatic check(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [OW-1:0] sx(input int v);
        if (v >= (1 << (DW - 1))) return OW'(v - (1 << DW));
        return OW'(v);
    endfunction

    function automatic logic [NW-1:0] ramp(input int base);
        logic [NW-1:0] v;
        for (int k = 0; k < N; k++) v[k*DW +: DW] = DW'(base + k);
        return v;
    endfunction

    function automatic logic [NW-1:0] rnd_vec();
        logic [NW-1:0] v;
        for (int k = 0; k < N; k++) v[k*DW +: DW] = DW'($urandom);
        return v;
    endfunction

    // Entered and left on a falling edge: check outputs, drive, advance model, clock.
    task automatic step(input logic r, input logic c, input logic rd, input logic cl,
                        input logic [NW-1:0] v);
        bit accept;
        bit has_beat;
        beat_t b;
        check("tvalid", OW'(m_tvalid), OW'(exp_q.size() != 0));
        check("busy", OW'(busy), OW'(exp_q.size() != 0));
        check("overrun", OW'(overrun), OW'(exp_ov));
        if (exp_q.size() != 0) begin
            check("tdata", m_tdata, exp_q[0].d);
            check("tlast", OW'(m_tlast), OW'(exp_q[0].l));
        end else begin
            check("tlast_idle", OW'(m_tlast), '0);
        end
        rst = r; capture = c; m_tready = rd; clr_overrun = cl; res_flat = v;
        if (r) begin
            exp_q.delete();
            exp_ov = 1'b0;
        end else begin
            has_beat = (exp_q.size() != 0) && rd;
            accept   = (exp_q.size() == 0) || (has_beat && exp_q.size() == 1);
            if (has_beat) void'(exp_q.pop_front());
            if (c && accept) begin
                for (int k = 0; k < N; k++) begin
                    b.d = sx(int'(v[k*DW +: DW]));
                    b.l = (k == N - 1);
                    exp_q.push_back(b);
                end
            end
            if (c && !accept) exp_ov = 1'b1;
            else if (cl) exp_ov = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain_all(input int rdy_mode);
        int i = 0;
        while (exp_q.size() != 0 && i < 64) begin
            step(0, 0, (rdy_mode == 0) ? 1'b1 : ((i % 4) == 0 || (i % 4) == 3), 0, '0);
            i++;
        end
        check("drain_bounded", OW'(exp_q.size()), '0);
    endtask

    initial begin
        logic [NW-1:0] a;
        logic [NW-1:0] bv;
        rst = 1'b1; capture = 1'b0; m_tready = 1'b0; clr_overrun = 1'b0; res_flat = '0;
        exp_q.delete();
        exp_ov = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("reset_tdata", m_tdata, '0);
        step(1, 0, 0, 0, '0);

        // Ramp snapshot streamed at full rate.
        step(0, 1, 1, 0, ramp(1));
        check("first_beat", m_tdata, 32'h0000_0001);
        for (int i = 0; i < N; i++) step(0, 0, 1, 0, '0);
        check("busy_after", OW'(busy), '0);

        // Sign extension corners.
        a = '0;
        a[0*DW +: DW] = 18'h3FFFF;
        a[1*DW +: DW] = 18'h20000;
        a[2*DW +: DW] = 18'h1FFFF;
        step(0, 1, 0, 0, a);
        check("sext_n0", m_tdata, 32'hFFFF_FFFF);
        step(0, 0, 1, 0, '0);
        check("sext_n1", m_tdata, 32'hFFFE_0000);
        step(0, 0, 1, 0, '0);
        check("sext_n2", m_tdata, 32'h0001_FFFF);
        drain_all(0);

        // Backpressure pattern 1,0,0,1.
        step(0, 1, 0, 0, ramp(16));
        drain_all(1);

        // Capture coinciding with the final beat chains with no gap.
        a  = ramp(1);
        bv = ramp(100);
        step(0, 1, 1, 0, a);
        for (int i = 0; i < N; i++) step(0, (i == N - 1), 1, 0, (i == N - 1) ? bv : '0);
        check("chain_valid", OW'(m_tvalid), 1);
        check("chain_node0", m_tdata, 32'd100);
        check("chain_ovr", OW'(overrun), '0);
        drain_all(0);

        // Capture dropped mid-drain at idx 3.
        step(0, 1, 1, 0, ramp(1));
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, '0);
        check("idx3_data", m_tdata, 32'd4);
        step(0, 1, 1, 0, ramp(200));
        check("after_drop", m_tdata, 32'd5);
        drain_all(0);
        check("ovr_set", OW'(overrun), 1);
        step(0, 0, 0, 1, '0);
        check("ovr_clr", OW'(overrun), '0);

        // Set beats clear when both coincide.
        step(0, 1, 0, 0, ramp(1));
        step(0, 1, 0, 1, ramp(50));
        check("ovr_set_wins", OW'(overrun), 1);
        drain_all(0);
        step(0, 0, 0, 1, '0);

        // Reset mid-drain at idx 5.
        step(0, 1, 1, 0, ramp(1));
        for (int i = 0; i < 5; i++) step(0, 0, 1, 0, '0);
        step(1, 0, 1, 0, '0);
        check("rst_valid", OW'(m_tvalid), '0);
        check("rst_busy", OW'(busy), '0);
        step(0, 1, 1, 0, ramp(300));
        check("post_rst_n0", m_tdata, 32'd300);
        drain_all(0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 19) == 0),
                 rnd_vec());
        end
        drain_all(0);
        step(0, 0, 0, 0, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
